axi_lite_wr_ctrl: RTL and testbench

//  AXI4-Lite slave write-channel sequencer that drives the write port of reg_block.

---
 rtl/axi_lite_wr_ctrl.sv | 137 +++++++++++++
 tb/tb_axi_lite_wr_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_wr_ctrl.sv
// AXI4-Lite write-channel sequencer feeding the reg_block write port.
// One outstanding write; range/strobe check gates the wr_en strobe.
module axi_lite_wr_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  output logic                    wr_en,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [DATA_WIDTH-1:0]   wr_data
);

  localparam int SW = DATA_WIDTH / 8;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT_W  = 3'd1;
  localparam logic [2:0] S_WAIT_AW = 3'd2;
  localparam logic [2:0] S_WRITE   = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  logic [2:0]            state;
  logic [2:0]            state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [SW-1:0]         strb_q;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  b_hs;
  logic [31:0]           idx;
  logic                  err;
  logic                  aw_rdy_nxt;
  logic                  w_rdy_nxt;

  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid & s_axi_wready;
  assign b_hs  = s_axi_bvalid & s_axi_bready;

  // Only full-word writes into implemented registers succeed.
  assign idx = 32'(addr_q[ADDR_WIDTH-1:2]);
  assign err = (idx >= 32'(REG_NUM)) ||
               (strb_q != {SW{1'b1}});

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (aw_hs && w_hs)
          state_nxt = S_WRITE;
        else if (aw_hs)
          state_nxt = S_WAIT_W;
        else if (w_hs)
          state_nxt = S_WAIT_AW;
      end
      S_WAIT_W: begin
        if (w_hs)
          state_nxt = S_WRITE;
      end
      S_WAIT_AW: begin
        if (aw_hs)
          state_nxt = S_WRITE;
      end
      S_WRITE: state_nxt = S_RESP;
      S_RESP: begin
        if (b_hs)
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    aw_rdy_nxt = 1'b0;
    w_rdy_nxt  = 1'b0;
    unique case (1'b1)
      (state_nxt == S_IDLE): begin
        aw_rdy_nxt = 1'b1;
        w_rdy_nxt  = 1'b1;
      end
      (state_nxt == S_WAIT_AW): aw_rdy_nxt = 1'b1;
      (state_nxt == S_WAIT_W):  w_rdy_nxt  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= 2'b00;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      strb_q        <= '0;
    end else begin
      state         <= state_nxt;
      s_axi_awready <= aw_rdy_nxt;
      s_axi_wready  <= w_rdy_nxt;
      if (aw_hs)
        addr_q <= s_axi_awaddr;
      if (w_hs) begin
        data_q <= s_axi_wdata;
        strb_q <= s_axi_wstrb;
      end
      wr_en <= (state == S_WRITE) && !err;
      if (state == S_WRITE) begin
        wr_addr <= addr_q;
        wr_data <= data_q;
      end
      // Held values are frozen through RESP, so bresp stays stable.
      if (state == S_RESP) begin
        if (b_hs) begin
          s_axi_bvalid <= 1'b0;
        end else begin
          s_axi_bvalid <= 1'b1;
          s_axi_bresp  <= err ? 2'b10 : 2'b00;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_wr_ctrl.sv
// Bench for axi_lite_wr_ctrl: directed plus randomized writes
// checked against a transaction-level register model.
module tb_axi_lite_wr_ctrl;

  localparam int AW = 6;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] s_axi_awaddr;
  logic          s_axi_awvalid;
  logic          s_axi_awready;
  logic [DW-1:0] s_axi_wdata;
  logic [3:0]    s_axi_wstrb;
  logic          s_axi_wvalid;
  logic          s_axi_wready;
  logic [1:0]    s_axi_bresp;
  logic          s_axi_bvalid;
  logic          s_axi_bready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  int n_total = 0;
  int n_pass  = 0;
  int wr_total = 0;

  logic [31:0] model  [0:15];
  logic [31:0] shadow [0:15];

  axi_lite_wr_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .REG_NUM(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_axi_awaddr(s_axi_awaddr),
    .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_txn(input logic [AW-1:0] addr,
                           input logic [31:0]   data,
                           input logic [3:0]    strb,
                           input int            aw_dly,
                           input int            w_dly,
                           input int            b_dly);
    bit       err;
    bit       aw_done, w_done, b_done, bv_seen;
    bit       aw_hs, w_hs, b_hs;
    int       aw_edge, w_edge, wr_edge, bv_edge;
    int       hs_edge, wr_cnt, wr_bad, bv_cnt;
    int       nstab, rdy_bad;
    logic [1:0] bresp0;
    logic [1:0] rdy_exp;
    err = ((int'(addr) / 4) >= 4) || (strb != 4'hF);
    aw_done = 0; w_done = 0; b_done = 0; bv_seen = 0;
    aw_edge = 0; w_edge = 0; wr_edge = 0; bv_edge = 0;
    wr_cnt = 0; wr_bad = 0; bv_cnt = 0;
    nstab = 0; rdy_bad = 0; bresp0 = 2'b00;
    s_axi_awaddr = addr;
    s_axi_wdata  = data;
    s_axi_wstrb  = strb;
    s_axi_bready = (b_dly == 0);
    for (int e = 0; e < 64 && !b_done; e++) begin
      s_axi_awvalid = !aw_done && (e >= aw_dly);
      s_axi_wvalid  = !w_done && (e >= w_dly);
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      b_hs  = s_axi_bvalid && s_axi_bready;
      tick();
      if (aw_hs) begin aw_done = 1; aw_edge = e + 1; end
      if (w_hs)  begin w_done = 1;  w_edge = e + 1;  end
      if (b_hs)  b_done = 1;
      if (wr_en) begin
        wr_cnt++;
        wr_edge = e + 1;
        if (wr_addr !== addr || wr_data !== data)
          wr_bad++;
        shadow[wr_addr[AW-1:2]] = wr_data;
      end
      if (s_axi_bvalid) begin
        if (!bv_seen) begin
          bv_seen = 1;
          bv_edge = e + 1;
          bresp0  = s_axi_bresp;
        end else if (s_axi_bresp !== bresp0) begin
          nstab++;
        end
        bv_cnt++;
      end
      if (b_dly > 0)
        s_axi_bready = (bv_cnt > b_dly);
      if (b_done)
        rdy_exp = 2'b11;
      else if (aw_done && w_done)
        rdy_exp = 2'b00;
      else
        rdy_exp = {!aw_done, !w_done};
      if ({s_axi_awready, s_axi_wready} !== rdy_exp)
        rdy_bad++;
    end
    s_axi_awvalid = 0;
    s_axi_wvalid  = 0;
    s_axi_bready  = 0;
    hs_edge = (aw_edge > w_edge) ? aw_edge : w_edge;
    chk("b_handshake", 64'(b_done), 64'd1);
    chk("aw_accept_edge", 64'(aw_edge), 64'(aw_dly + 1));
    chk("w_accept_edge", 64'(w_edge), 64'(w_dly + 1));
    chk("wr_en_count", 64'(wr_cnt), err ? 64'd0 : 64'd1);
    if (!err)
      chk("wr_en_edge", 64'(wr_edge), 64'(hs_edge + 1));
    chk("wr_addr_data", 64'(wr_bad), 64'd0);
    chk("bvalid_edge", 64'(bv_edge), 64'(hs_edge + 2));
    chk("bresp", 64'(bresp0), err ? 64'd2 : 64'd0);
    chk("bresp_stable", 64'(nstab), 64'd0);
    chk("ready_seq", 64'(rdy_bad), 64'd0);
    chk("bvalid_drop", 64'(s_axi_bvalid), 64'd0);
    if (!err)
      model[int'(addr) / 4] = data;
    wr_total += wr_cnt;
  endtask

  task automatic do_reset();
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
  endtask

  initial begin
    int wr_base;
    int bad;
    logic [31:0] d;
    logic [3:0]  st;
    for (int i = 0; i < 16; i++) begin
      model[i]  = '0;
      shadow[i] = '0;
    end
    rst_n = 0;
    s_axi_awaddr = '0; s_axi_awvalid = 0;
    s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 0; s_axi_bready = 0;
    tick();
    tick();
    chk("reset_outputs",
        64'({s_axi_awready, s_axi_wready, s_axi_bvalid,
             s_axi_bresp, wr_en, wr_addr, wr_data}),
        64'd0);
    rst_n = 1;
    tick();
    chk("ready_after_reset",
        64'({s_axi_awready, s_axi_wready}), 64'd3);

    // same-cycle AW/W
    write_txn(6'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    chk("readback_1", 64'(shadow[1]), 64'(model[1]));
    // W three cycles ahead of AW
    write_txn(6'h08, 32'h12345678, 4'hF, 3, 0, 0);
    // out-of-range index and partial strobe
    write_txn(6'h10, $urandom, 4'hF, 0, 0, 0);
    write_txn(6'h00, $urandom, 4'h3, 0, 0, 0);
    // slow bready, then immediate next AW
    write_txn(6'h0C, $urandom, 4'hF, 0, 0, 5);
    write_txn(6'h04, $urandom, 4'hF, 0, 0, 0);

    // reset while AW is held
    s_axi_awaddr = 6'h04;
    s_axi_awvalid = 1;
    tick();
    s_axi_awvalid = 0;
    chk("wait_w_ready",
        64'({s_axi_awready, s_axi_wready}), 64'd1);
    rst_n = 0;
    tick();
    chk("midtxn_reset_outputs",
        64'({s_axi_awready, s_axi_wready, s_axi_bvalid,
             s_axi_bresp, wr_en, wr_addr, wr_data}),
        64'd0);
    rst_n = 1;
    tick();
    s_axi_wdata = 32'hA5A5_0001;
    s_axi_wstrb = 4'hF;
    s_axi_wvalid = 1;
    tick();
    s_axi_wvalid = 0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (wr_en !== 1'b0 || s_axi_bvalid !== 1'b0)
        bad++;
      tick();
    end
    chk("no_write_after_reset", 64'(bad), 64'd0);
    chk("wait_aw_ready",
        64'({s_axi_awready, s_axi_wready}), 64'd2);
    do_reset();

    // back-to-back to all indices with random skew
    wr_base = wr_total;
    for (int i = 0; i < 4; i++)
      write_txn(AW'(i * 4), $urandom, 4'hF,
                $urandom_range(0, 3),
                $urandom_range(0, 3), 0);
    chk("b2b_wr_pulses", 64'(wr_total - wr_base), 64'd4);
    for (int i = 0; i < 4; i++)
      chk("b2b_reg", 64'(shadow[i]), 64'(model[i]));

    // random mix including errors
    for (int k = 0; k < 20; k++) begin
      d  = $urandom;
      st = ($urandom_range(0, 3) == 0) ?
           4'($urandom) : 4'hF;
      write_txn(AW'($urandom_range(0, 63)), d, st,
                $urandom_range(0, 3),
                $urandom_range(0, 3),
                $urandom_range(0, 2));
    end
    for (int i = 0; i < 4; i++)
      chk("final_reg", 64'(shadow[i]), 64'(model[i]));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
